// File: rtl/scr1_imem_match_trace.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scr1_imem_match_trace: passive IMEM-response tap capturing matching   |
// | instructions with timestamp and CSR snapshot into a drainable FIFO.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module scr1_imem_match_trace #(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [6:0]                    cfg_opcode,
  input  logic [2:0]                    cfg_funct3,
  input  logic                          cfg_funct3_en,
  input  logic                          cfg_stop_on_full,
  input  logic                          cfg_clr,
  input  logic [1:0]                    imem_resp,
  input  logic [31:0]                   imem_rdata,
  input  logic                          csr_mstatus_mie,
  input  logic                          csr_mstatus_mpie,
  input  logic [31:0]                   csr_mepc,
  input  logic                          csr_mcause_i,
  input  logic [3:0]                    csr_mcause_ec,
  output logic                          trc_valid,
  input  logic                          trc_ready,
  output logic [TS_WIDTH-1:0]           trc_ts,
  output logic [31:0]                   trc_instr,
  output logic [31:0]                   trc_mepc,
  output logic                          trc_mcause_i,
  output logic [3:0]                    trc_mcause_ec,
  output logic                          trc_mie,
  output logic                          trc_mpie,
  output logic [$clog2(FIFO_DEPTH):0]   trc_level,
  output logic [15:0]                   trc_drop_cnt,
  output logic                          trc_halted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TS_WIDTH + 71;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                halted;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic [TS_WIDTH-1:0] ts;
  logic [15:0]         drop_cnt;

  logic          match;
  logic          full;
  logic          not_empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;

  assign match = (imem_resp == 2'b01) &&
                 (imem_rdata[6:0] == cfg_opcode) &&
                 (!cfg_funct3_en || (imem_rdata[14:12] == cfg_funct3));

  assign full      = (count == DEPTH_CNT);
  assign not_empty = (count != '0);

  // cfg_clr wins over every FIFO and drop-counter update in its cycle
  assign pop  = not_empty && trc_ready && !cfg_clr;
  assign push = !cfg_clr && match && (state == ST_RUN) && (!full || pop);
  assign drop = !cfg_clr && match &&
                (((state == ST_RUN) && full && !pop) || (state == ST_HALT));

  assign entry = {ts, imem_rdata, csr_mepc, csr_mcause_i, csr_mcause_ec,
                  csr_mstatus_mie, csr_mstatus_mpie};

  always_comb begin
    state_nxt = state;
    if (!cfg_en) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:  state_nxt = ST_RUN;
        ST_RUN:  if (!cfg_clr && match && full && !pop && cfg_stop_on_full)
                   state_nxt = ST_HALT;
        ST_HALT: if (cfg_clr) state_nxt = ST_RUN;
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == ST_HALT);
      ts     <= ts + TS_WIDTH'(1);
      if (cfg_clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
        if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Storage has no reset; outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign head = not_empty ? mem[rd_ptr] : '0;

  assign trc_valid = not_empty;
  assign {trc_ts, trc_instr, trc_mepc, trc_mcause_i, trc_mcause_ec,
          trc_mie, trc_mpie} = head;
  assign trc_level    = count;
  assign trc_drop_cnt = drop_cnt;
  assign trc_halted   = halted;

endmodule
`default_nettype wire

// File: tb/tb_scr1_imem_match_trace.sv
`default_nettype none
// Directed testbench for scr1_imem_match_trace: filter, snapshot, overflow,
// stop-on-full, back-to-back, clear and asynchronous reset scenarios.
module tb_scr1_imem_match_trace;

  localparam logic [31:0] XOR_I = 32'h0020C1B3;
  localparam logic [31:0] ADD_I = 32'h002081B3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en, cfg_funct3_en, cfg_stop_on_full, cfg_clr;
  logic [6:0]  cfg_opcode;
  logic [2:0]  cfg_funct3;
  logic [1:0]  imem_resp;
  logic [31:0] imem_rdata;
  logic        csr_mstatus_mie, csr_mstatus_mpie, csr_mcause_i;
  logic [31:0] csr_mepc;
  logic [3:0]  csr_mcause_ec;
  logic        trc_valid, trc_ready;
  logic [31:0] trc_ts, trc_instr, trc_mepc;
  logic        trc_mcause_i, trc_mie, trc_mpie, trc_halted;
  logic [3:0]  trc_mcause_ec;
  logic [3:0]  trc_level;
  logic [15:0] trc_drop_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  scr1_imem_match_trace #(.FIFO_DEPTH(8), .TS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_opcode(cfg_opcode),
    .cfg_funct3(cfg_funct3), .cfg_funct3_en(cfg_funct3_en),
    .cfg_stop_on_full(cfg_stop_on_full), .cfg_clr(cfg_clr),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .csr_mstatus_mie(csr_mstatus_mie), .csr_mstatus_mpie(csr_mstatus_mpie),
    .csr_mepc(csr_mepc), .csr_mcause_i(csr_mcause_i),
    .csr_mcause_ec(csr_mcause_ec), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_ts(trc_ts), .trc_instr(trc_instr),
    .trc_mepc(trc_mepc), .trc_mcause_i(trc_mcause_i),
    .trc_mcause_ec(trc_mcause_ec), .trc_mie(trc_mie), .trc_mpie(trc_mpie),
    .trc_level(trc_level), .trc_drop_cnt(trc_drop_cnt),
    .trc_halted(trc_halted)
  );

  function automatic logic [31:0] mk(input int i);
    return {i[7:0], 24'h00C033};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_match(input logic [31:0] ins);
    imem_resp  = 2'b01;
    imem_rdata = ins;
  endtask

  task automatic idle();
    imem_resp  = 2'b00;
    imem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_en = 1'b1; cfg_opcode = 7'b0110011; cfg_funct3 = 3'b100;
    cfg_funct3_en = 1'b1; cfg_stop_on_full = 1'b0; cfg_clr = 1'b0;
    trc_ready = 1'b0; idle();
    csr_mstatus_mie = 1'b0; csr_mstatus_mpie = 1'b0; csr_mepc = 32'h0;
    csr_mcause_i = 1'b0; csr_mcause_ec = 4'h0;
    cyc(); cyc();
    rst_n = 1'b1;
    checks++; if (trc_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", trc_valid); else passed++;
    checks++; if (trc_level !== 4'd0) $display("FAIL rst_level: got %0d want 0", trc_level); else passed++;
    checks++; if (trc_drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d want 0", trc_drop_cnt); else passed++;
    checks++; if (trc_halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", trc_halted); else passed++;
    checks++; if (trc_instr !== 32'h0 || trc_ts !== 32'h0) $display("FAIL rst_payload: got %h/%h want 0/0", trc_instr, trc_ts); else passed++;
  endtask

  // Must follow test_reset directly: the match lands on timestamp 5
  task automatic test_snapshot();
    repeat (5) cyc();
    drive_match(XOR_I);
    csr_mepc = 32'h8000_0100; csr_mcause_i = 1'b1; csr_mcause_ec = 4'd7;
    csr_mstatus_mie = 1'b1; csr_mstatus_mpie = 1'b0;
    checks++; if (trc_valid !== 1'b0) $display("FAIL snap_nobypass: got %b want 0", trc_valid); else passed++;
    cyc();
    idle();
    csr_mepc = 32'h1234_5678; csr_mcause_i = 1'b0; csr_mcause_ec = 4'd2;
    csr_mstatus_mie = 1'b0; csr_mstatus_mpie = 1'b1;
    checks++; if (trc_valid !== 1'b1) $display("FAIL snap_valid: got %b want 1", trc_valid); else passed++;
    checks++; if (trc_ts !== 32'd5) $display("FAIL snap_ts: got %0d want 5", trc_ts); else passed++;
    checks++; if (trc_instr !== XOR_I) $display("FAIL snap_instr: got %h want %h", trc_instr, XOR_I); else passed++;
    cyc();
    checks++; if (trc_mepc !== 32'h8000_0100) $display("FAIL snap_mepc: got %h want 80000100", trc_mepc); else passed++;
    checks++; if ({trc_mcause_i, trc_mcause_ec, trc_mie, trc_mpie} !== {1'b1, 4'd7, 1'b1, 1'b0})
      $display("FAIL snap_csr: got %b want 1011110", {trc_mcause_i, trc_mcause_ec, trc_mie, trc_mpie}); else passed++;
    trc_ready = 1'b1; cyc(); trc_ready = 1'b0;
    checks++; if (trc_valid !== 1'b0 || trc_mepc !== 32'h0) $display("FAIL snap_popped: got %b/%h want 0/0", trc_valid, trc_mepc); else passed++;
  endtask

  task automatic test_filter();
    drive_match(XOR_I);
    cyc();
    drive_match(ADD_I);
    checks++; if (trc_valid !== 1'b1) $display("FAIL filt_valid_rise: got %b want 1", trc_valid); else passed++;
    cyc();
    imem_resp = 2'b00; imem_rdata = XOR_I;
    cyc();
    idle(); cyc();
    checks++; if (trc_level !== 4'd1) $display("FAIL filt_level: got %0d want 1", trc_level); else passed++;
    checks++; if (trc_instr !== XOR_I) $display("FAIL filt_instr: got %h want %h", trc_instr, XOR_I); else passed++;
    trc_ready = 1'b1; cyc(); trc_ready = 1'b0;
    cfg_funct3_en = 1'b0;
    drive_match(ADD_I); cyc(); idle();
    checks++; if (trc_level !== 4'd1 || trc_instr !== ADD_I) $display("FAIL filt_opcode_only: got %0d/%h want 1/%h", trc_level, trc_instr, ADD_I); else passed++;
    trc_ready = 1'b1; cyc(); trc_ready = 1'b0;
    cfg_funct3_en = 1'b1;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 11; i++) begin
      drive_match(mk(i)); cyc();
    end
    idle();
    checks++; if (trc_level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", trc_level); else passed++;
    checks++; if (trc_drop_cnt !== 16'd3) $display("FAIL ovf_drop: got %0d want 3", trc_drop_cnt); else passed++;
    checks++; if (trc_halted !== 1'b0) $display("FAIL ovf_halted: got %b want 0", trc_halted); else passed++;
    cyc();
    checks++; if (trc_instr !== mk(1)) $display("FAIL ovf_stall_stable: got %h want %h", trc_instr, mk(1)); else passed++;
    trc_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (trc_instr !== mk(k)) $display("FAIL ovf_order%0d: got %h want %h", k, trc_instr, mk(k)); else passed++;
      cyc();
    end
    trc_ready = 1'b0;
    checks++; if (trc_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", trc_valid); else passed++;
  endtask

  task automatic test_stop_on_full();
    cfg_clr = 1'b1; cyc(); cfg_clr = 1'b0;
    cfg_stop_on_full = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drive_match(mk(8'h20 + i)); cyc();
    end
    checks++; if (trc_halted !== 1'b1) $display("FAIL sof_halted: got %b want 1", trc_halted); else passed++;
    checks++; if (trc_drop_cnt !== 16'd1) $display("FAIL sof_drop1: got %0d want 1", trc_drop_cnt); else passed++;
    trc_ready = 1'b1;
    drive_match(mk(8'h30)); cyc();
    drive_match(mk(8'h31)); cyc();
    idle(); trc_ready = 1'b0;
    checks++; if (trc_level !== 4'd6) $display("FAIL sof_level: got %0d want 6", trc_level); else passed++;
    checks++; if (trc_drop_cnt !== 16'd3) $display("FAIL sof_drop3: got %0d want 3", trc_drop_cnt); else passed++;
    checks++; if (trc_instr !== mk(8'h23)) $display("FAIL sof_head: got %h want %h", trc_instr, mk(8'h23)); else passed++;
    cfg_clr = 1'b1; cyc(); cfg_clr = 1'b0;
    checks++; if ({trc_level, trc_drop_cnt, trc_halted} !== 21'd0)
      $display("FAIL sof_clr: got level %0d drop %0d halted %b want 0 0 0", trc_level, trc_drop_cnt, trc_halted); else passed++;
    drive_match(mk(8'h40)); cyc(); idle();
    checks++; if (trc_level !== 4'd1 || trc_instr !== mk(8'h40)) $display("FAIL sof_recapture: got %0d/%h want 1/%h", trc_level, trc_instr, mk(8'h40)); else passed++;
    trc_ready = 1'b1; cyc(); trc_ready = 1'b0;
    cfg_stop_on_full = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive_match(mk(8'h50 + i)); cyc();
    end
    drive_match(mk(8'h60)); trc_ready = 1'b1; cyc();
    idle(); trc_ready = 1'b0;
    checks++; if (trc_level !== 4'd8) $display("FAIL b2b_level: got %0d want 8", trc_level); else passed++;
    checks++; if (trc_drop_cnt !== 16'd0) $display("FAIL b2b_drop: got %0d want 0", trc_drop_cnt); else passed++;
    checks++; if (trc_instr !== mk(8'h51)) $display("FAIL b2b_head: got %h want %h", trc_instr, mk(8'h51)); else passed++;
    trc_ready = 1'b1; repeat (7) cyc(); trc_ready = 1'b0;
    checks++; if (trc_level !== 4'd1 || trc_instr !== mk(8'h60)) $display("FAIL b2b_last: got %0d/%h want 1/%h", trc_level, trc_instr, mk(8'h60)); else passed++;
    trc_ready = 1'b1; cyc(); trc_ready = 1'b0;
  endtask

  task automatic test_clr_with_match();
    for (int i = 0; i < 9; i++) begin
      drive_match(mk(8'h70 + i)); cyc();
    end
    checks++; if (trc_drop_cnt !== 16'd1) $display("FAIL clr_pre_drop: got %0d want 1", trc_drop_cnt); else passed++;
    drive_match(mk(8'h7F)); cfg_clr = 1'b1; cyc();
    cfg_clr = 1'b0; idle();
    checks++; if (trc_level !== 4'd0 || trc_drop_cnt !== 16'd0) $display("FAIL clr_match: got %0d/%0d want 0/0", trc_level, trc_drop_cnt); else passed++;
    cyc();
    checks++; if (trc_valid !== 1'b0) $display("FAIL clr_not_stored: got %b want 0", trc_valid); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      drive_match(mk(8'h90 + i)); cyc();
    end
    idle();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (trc_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", trc_valid); else passed++;
    checks++; if (trc_level !== 4'd0) $display("FAIL arst_level: got %0d want 0", trc_level); else passed++;
    checks++; if (trc_drop_cnt !== 16'd0) $display("FAIL arst_drop: got %0d want 0", trc_drop_cnt); else passed++;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_filter();
    test_overflow();
    test_stop_on_full();
    test_back_to_back();
    test_clr_with_match();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
